// File: rtl/regfile_sp.sv
// regfile_sp - general-purpose register file for the 8-bit MIPS datapath.
//
// Holds 2**ADDR_W registers of WIDTH bits. One of them (SP_IDX) is the stack
// pointer. Port 3 writes it like any other register. The push/pop inputs also
// step it in hardware, and those steps are bounds-checked.
//
// Ports
//   clk       in   1       rising-edge clock
//   rst       in   1       asynchronous active-high reset
//   wr_en3    in   1       write enable, port 3
//   wr_addr3  in   ADDR_W  write address, port 3
//   wr_d3     in   WIDTH   write data, port 3
//   rd_addr1  in   ADDR_W  read address, port 1
//   rd_d1     out  WIDTH   read data, port 1 (combinational)
//   rd_addr2  in   ADDR_W  read address, port 2
//   rd_d2     out  WIDTH   read data, port 2 (combinational)
//   sp_push   in   1       decrement SP
//   sp_pop    in   1       increment SP
//   sp_out    out  WIDTH   current SP register value
//   sp_err    out  1       one-cycle pulse after a rejected push/pop
module regfile_sp #(
  parameter int               WIDTH    = 8,
  parameter int               ADDR_W   = 2,
  parameter int               SP_IDX   = 3,
  parameter logic [WIDTH-1:0] SP_RESET = 8'hFF,
  parameter logic [WIDTH-1:0] SP_LIMIT = 8'h00,
  parameter bit               ZERO_REG = 1'b0,
  parameter bit               BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en3,
  input  logic [ADDR_W-1:0] wr_addr3,
  input  logic [WIDTH-1:0]  wr_d3,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [WIDTH-1:0]  rd_d1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_d2,
  input  logic              sp_push,
  input  logic              sp_pop,
  output logic [WIDTH-1:0]  sp_out,
  output logic              sp_err
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] SP_A  = ADDR_W'(SP_IDX);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok;
  logic             sp_wr;

  // Read mux. The hard-zero check comes before the bypass, so a write to r0
  // that is in flight never shows up on a read port.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [WIDTH-1:0]  stored,
    input logic              wen,
    input logic [ADDR_W-1:0] waddr,
    input logic [WIDTH-1:0]  wdata
  );
    if (ZERO_REG && addr == '0) return '0;
    if (BYPASS && wen && waddr == addr) return wdata;
    return stored;
  endfunction

  // Drop writes that target the hard-zero register.
  assign wr_ok = wr_en3 && !(ZERO_REG && wr_addr3 == '0);
  // A port-3 write to SP takes priority over push/pop on the same edge.
  assign sp_wr = wr_en3 && (wr_addr3 == SP_A);

  assign rd_d1  = read_port(rd_addr1, regs[rd_addr1], wr_en3, wr_addr3, wr_d3);
  assign rd_d2  = read_port(rd_addr2, regs[rd_addr2], wr_en3, wr_addr3, wr_d3);
  assign sp_out = regs[SP_A];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      sp_err <= 1'b0;
    end else begin
      sp_err <= 1'b0;
      if (wr_ok) regs[wr_addr3] <= wr_d3;
      // Push and pop together cancel. The bounds are tested by equality only,
      // so an SP that was written outside the range can still step.
      if (!sp_wr && (sp_push ^ sp_pop)) begin
        if (sp_push) begin
          if (regs[SP_A] == SP_LIMIT) sp_err <= 1'b1;
          else                        regs[SP_A] <= regs[SP_A] - WIDTH'(1);
        end else begin
          if (regs[SP_A] == SP_RESET) sp_err <= 1'b1;
          else                        regs[SP_A] <= regs[SP_A] + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sp.sv
// Directed bench for regfile_sp. Three instances share the same stimulus:
// the default one (BYPASS=1, ZERO_REG=0), one with BYPASS=0, and one with
// ZERO_REG=1.
module tb_regfile_sp;

  logic       clk, rst, wr_en3, sp_push, sp_pop;
  logic [1:0] wr_addr3, rd_addr1, rd_addr2;
  logic [7:0] wr_d3;

  logic [7:0] rd1_a, rd2_a, sp_a;  logic err_a;
  logic [7:0] rd1_b, rd2_b, sp_b;  logic err_b;
  logic [7:0] rd1_z, rd2_z, sp_z;  logic err_z;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_sp dut (
    .clk(clk), .rst(rst), .wr_en3(wr_en3), .wr_addr3(wr_addr3), .wr_d3(wr_d3),
    .rd_addr1(rd_addr1), .rd_d1(rd1_a), .rd_addr2(rd_addr2), .rd_d2(rd2_a),
    .sp_push(sp_push), .sp_pop(sp_pop), .sp_out(sp_a), .sp_err(err_a)
  );

  regfile_sp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .wr_en3(wr_en3), .wr_addr3(wr_addr3), .wr_d3(wr_d3),
    .rd_addr1(rd_addr1), .rd_d1(rd1_b), .rd_addr2(rd_addr2), .rd_d2(rd2_b),
    .sp_push(sp_push), .sp_pop(sp_pop), .sp_out(sp_b), .sp_err(err_b)
  );

  regfile_sp #(.ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst), .wr_en3(wr_en3), .wr_addr3(wr_addr3), .wr_d3(wr_d3),
    .rd_addr1(rd_addr1), .rd_d1(rd1_z), .rd_addr2(rd_addr2), .rd_d2(rd2_z),
    .sp_push(sp_push), .sp_pop(sp_pop), .sp_out(sp_z), .sp_err(err_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after the falling edge.
  task automatic drive(input logic wen, input logic [1:0] waddr, input logic [7:0] wd,
                       input logic push, input logic pop);
    @(negedge clk);
    wr_en3 = wen; wr_addr3 = waddr; wr_d3 = wd; sp_push = push; sp_pop = pop;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sp(input string tag, input logic [7:0] sp, input logic err);
    check({tag, "_sp_a"}, sp_a, sp);
    check({tag, "_sp_b"}, sp_b, sp);
    check({tag, "_sp_z"}, sp_z, sp);
    check({tag, "_err_a"}, {7'b0, err_a}, {7'b0, err});
    check({tag, "_err_z"}, {7'b0, err_z}, {7'b0, err});
  endtask

  // push/pop sequence from reset: op 1=push, 2=pop, 3=both
  logic [1:0] ops   [6] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
  logic [7:0] sp_exp[6] = '{8'hFE, 8'hFD, 8'hFC, 8'hFD, 8'hFE, 8'hFE};

  initial begin
    rst = 1'b1; wr_en3 = 0; wr_addr3 = 0; wr_d3 = 0; sp_push = 0; sp_pop = 0;
    rd_addr1 = 0; rd_addr2 = 0;
    step();
    rd_addr1 = 2'd3;
    #1;
    check("rst_sp", sp_a, 8'hFF);
    check("rst_rd_sp", rd1_a, 8'hFF);
    check("rst_err", {7'b0, err_a}, 8'h00);
    @(negedge clk) rst = 1'b0;

    // ---- async reset between edges ----
    drive(1'b1, 2'd1, 8'h5A, 1'b0, 1'b1);      // write r1, pop at empty stack
    step();
    wr_en3 = 0; sp_pop = 0; rd_addr1 = 2'd1;
    #1;
    check("wr_r1", rd1_a, 8'h5A);
    check("pop_empty_err", {7'b0, err_a}, 8'h01);
    rst = 1'b1;
    #1;
    check("arst_r1", rd1_a, 8'h00);
    check("arst_sp", sp_a, 8'hFF);
    check("arst_err", {7'b0, err_a}, 8'h00);
    rst = 1'b0;

    // ---- write/read and bypass ----
    drive(1'b1, 2'd2, 8'h3C, 1'b0, 1'b0);
    rd_addr1 = 2'd2;
    #1;
    check("byp_rd1", rd1_a, 8'h3C);
    check("nobyp_rd1_old", rd1_b, 8'h00);
    check("byp_z_rd1", rd1_z, 8'h3C);
    step();
    wr_en3 = 0; rd_addr2 = 2'd2;
    #1;
    check("after_rd2_a", rd2_a, 8'h3C);
    check("after_rd2_b", rd2_b, 8'h3C);
    check("after_rd1_b", rd1_b, 8'h3C);

    // ---- push/pop sequence ----
    rd_addr1 = 2'd3;
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    check("push_rd_pre_edge", rd1_a, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) drive(1'b0, 2'd0, 8'h00, ops[i][0], ops[i][1]);
      step();
      check_sp($sformatf("pp%0d", i), sp_exp[i], 1'b0);
    end

    // ---- bounds ----
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);  step(); check_sp("pop_to_ff", 8'hFF, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);  step(); check_sp("underflow", 8'hFF, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);  step(); check_sp("idle1", 8'hFF, 1'b0);
    drive(1'b1, 2'd3, 8'h00, 1'b0, 1'b0);  step(); check_sp("wr_sp0", 8'h00, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);  step(); check_sp("overflow", 8'h00, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);  step(); check_sp("overflow2", 8'h00, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);  step(); check_sp("idle2", 8'h00, 1'b0);

    // ---- write vs push conflict ----
    drive(1'b1, 2'd3, 8'h80, 1'b1, 1'b0);
    check("conf_byp_rd1", rd1_a, 8'h80);
    step();
    check_sp("conflict", 8'h80, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);  step(); check_sp("push_80", 8'h7F, 1'b0);

    // ---- hard-zero register ----
    drive(1'b1, 2'd0, 8'hAA, 1'b0, 1'b0);
    rd_addr1 = 2'd0;
    #1;
    check("z_rd1_same", rd1_z, 8'h00);
    check("nz_rd1_same", rd1_a, 8'hAA);
    step();
    wr_en3 = 0;
    #1;
    check("z_rd1_after", rd1_z, 8'h00);
    check("nz_rd1_after", rd1_a, 8'hAA);

    // ---- reset overrides a push on the same edge ----
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    check("rst_ovr_sp", sp_a, 8'hFF);
    @(negedge clk) rst = 1'b0;
    step();
    check("resume_push", sp_a, 8'hFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
